// File: rtl/sa_processing_element_pool.sv
`default_nettype none
// sa_processing_element_pool: signed MAX / MIN / saturating-SUM pooling PE with a
// self-closing window counter and registered a/b/valid propagation. Rev 1.0
module sa_processing_element_pool #(
  parameter  int IA_W    = 16,
  parameter  int IB_W    = 16,
  parameter  int OC_W    = 24,
  parameter  int WIN_MAX = 16,
  localparam int CNT_W   = $clog2(WIN_MAX + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IA_W-1:0]  a,
  input  logic             a_valid,
  input  logic [IB_W-1:0]  b,
  input  logic [OC_W-1:0]  c,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] win_len,
  input  logic             reg_clear,
  input  logic             pipeline_en,
  input  logic             preload_en,
  output logic [IA_W-1:0]  a_out,
  output logic [IB_W-1:0]  b_out,
  output logic             a_valid_out,
  output logic [OC_W-1:0]  c_out,
  output logic             c_valid
);

  localparam logic [1:0]             MODE_MIN  = 2'b01;
  localparam logic [1:0]             MODE_SUM  = 2'b10;
  localparam logic [CNT_W-1:0]       WIN_MAX_C = CNT_W'(WIN_MAX);
  localparam logic signed [OC_W-1:0] SAT_POS   = {1'b0, {(OC_W-1){1'b1}}};
  localparam logic signed [OC_W-1:0] SAT_NEG   = {1'b1, {(OC_W-1){1'b0}}};

  typedef enum logic [0:0] {S_EMPTY = 1'b0, S_ACCUM = 1'b1} state_t;

  state_t                 state_q;
  logic [IA_W-1:0]        a_q;
  logic [IB_W-1:0]        b_q;
  logic                   a_valid_q;
  logic                   c_valid_q;
  logic signed [OC_W-1:0] acc_q;
  logic signed [OC_W-1:0] c_out_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       win_q;
  logic [1:0]             mode_q;

  logic signed [IA_W-1:0] a_s;
  logic signed [OC_W-1:0] a_ext;
  logic signed [OC_W:0]   sum_ext;
  logic signed [OC_W-1:0] acc_d;
  logic [CNT_W-1:0]       cnt_d;
  logic [CNT_W-1:0]       eff_win;
  logic [CNT_W-1:0]       cur_win;
  logic                   done;

  always_comb begin
    if (win_len == '0)
      eff_win = CNT_W'(1);
    else if (win_len > WIN_MAX_C)
      eff_win = WIN_MAX_C;
    else
      eff_win = win_len;

    a_s     = a;
    a_ext   = OC_W'(a_s);
    sum_ext = {acc_q[OC_W-1], acc_q} + {a_ext[OC_W-1], a_ext};

    // First sample of a window seeds the accumulator; mode 11 falls through to MAX.
    if (state_q == S_EMPTY)
      acc_d = a_ext;
    else if (mode_q == MODE_MIN)
      acc_d = (a_ext < acc_q) ? a_ext : acc_q;
    else if (mode_q == MODE_SUM) begin
      if (sum_ext[OC_W] != sum_ext[OC_W-1])
        acc_d = sum_ext[OC_W] ? SAT_NEG : SAT_POS;
      else
        acc_d = sum_ext[OC_W-1:0];
    end else
      acc_d = (a_ext > acc_q) ? a_ext : acc_q;

    cur_win = (state_q == S_EMPTY) ? eff_win : win_q;
    cnt_d   = (state_q == S_EMPTY) ? CNT_W'(1) : cnt_q + 1'b1;
    done    = (cnt_d == cur_win);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_EMPTY;
      a_q       <= '0;
      b_q       <= '0;
      a_valid_q <= 1'b0;
      c_valid_q <= 1'b0;
      acc_q     <= '0;
      c_out_q   <= '0;
      cnt_q     <= '0;
      win_q     <= '0;
      mode_q    <= '0;
    end else if (reg_clear) begin
      state_q   <= S_EMPTY;
      a_q       <= '0;
      b_q       <= '0;
      a_valid_q <= 1'b0;
      c_valid_q <= 1'b0;
      acc_q     <= '0;
      c_out_q   <= '0;
      cnt_q     <= '0;
      win_q     <= '0;
      mode_q    <= '0;
    end else if (!pipeline_en) begin
      c_valid_q <= 1'b0;
    end else begin
      a_q       <= a;
      b_q       <= b;
      a_valid_q <= a_valid;
      c_valid_q <= 1'b0;
      // Window configuration is captured only when a window opens.
      if (state_q == S_EMPTY && (preload_en || a_valid)) begin
        win_q  <= eff_win;
        mode_q <= mode;
      end
      if (preload_en) begin
        acc_q   <= c;
        state_q <= S_ACCUM;
      end else if (a_valid) begin
        acc_q <= acc_d;
        if (done) begin
          c_out_q   <= acc_d;
          c_valid_q <= 1'b1;
          cnt_q     <= '0;
          state_q   <= S_EMPTY;
        end else begin
          cnt_q     <= cnt_d;
          state_q   <= S_ACCUM;
        end
      end
    end
  end

  assign a_out       = a_q;
  assign b_out       = b_q;
  assign a_valid_out = a_valid_q;
  assign c_out       = c_out_q;
  assign c_valid     = c_valid_q;

endmodule
`default_nettype wire

// File: doc/sa_processing_element_pool.md
Name: sa_processing_element_pool

Overview:
Parametrised pooling processing element for the systolic array and successor to the FP16 max PE. It works on signed integer operands of configurable width and supports three run-time modes: MAX, MIN and saturating SUM. A window counter closes the reduction by itself after a programmable number of valid samples and emits a one-cycle result-valid pulse, so no external result_load is needed. a, b and the valid flag pass through registered propagation stages to the neighbouring PE.

Parameters:
IA_W, 16, activation width (signed two's complement)
IB_W, 16, weight width (propagated only)
OC_W, 24, accumulator/result width; must satisfy OC_W >= IA_W
WIN_MAX, 16, maximum window length
CNT_W, $clog2(WIN_MAX+1), window counter width (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
a  in  IA_W  input sample
a_valid  in  1  a is a valid sample
b  in  IB_W  weight operand, propagation only
c  in  OC_W  preload seed value
mode  in  2  00 MAX, 01 MIN, 10 SUM, 11 treated as MAX
win_len  in  CNT_W  samples per window; 0 treated as 1; values above WIN_MAX clamp to WIN_MAX
reg_clear  in  1  synchronous clear
pipeline_en  in  1  global pipeline enable
preload_en  in  1  seed accumulator from c
a_out  out  IA_W  registered a
b_out  out  IB_W  registered b
a_valid_out  out  1  registered a_valid
c_out  out  OC_W  last completed window result
c_valid  out  1  one-cycle pulse when c_out updates

Behaviour:
- Reset (rst high, async): all registers 0. Outputs a_out, b_out, a_valid_out, c_out and c_valid are 0. State is EMPTY.
- Priority at each rising edge: rst > reg_clear > pipeline_en==0 (hold) > preload_en > sample.
- reg_clear: synchronously zeroes the same set as rst, regardless of pipeline_en.
- pipeline_en=0: every register holds, except c_valid, which is driven 0.
- Propagation (pipeline_en=1): a_q<=a, b_q<=b, a_valid_q<=a_valid. Latency is 1 cycle and is independent of state.
- Internal state: acc (OC_W), cnt (CNT_W), win_q, mode_q, and FSM {EMPTY, ACCUM}.
- EMPTY, valid sample: acc<=sext(a), cnt<=1, win_q<=eff_win_len, mode_q<=mode. If eff_win_len==1 the window completes on this same edge.
- ACCUM, valid sample: acc<=op(acc, sext(a)), cnt<=cnt+1.
  - op for MAX/MIN is a signed compare.
  - op for SUM is signed add saturated to [-2^(OC_W-1), 2^(OC_W-1)-1].
- mode and win_len are sampled only at window start. Changes mid-window are ignored until the next window.
- Window completion: a valid sample that makes cnt reach win_q causes, on that same edge:
  - c_out<=op result (including the completing sample),
  - c_valid<=1,
  - cnt<=0 and state<=EMPTY.
  A sample on the next cycle starts the next window with no bubble.
- c_valid is high for exactly one cycle per completed window. c_out holds its value until the next completion.
- preload_en (with pipeline_en=1): acc<=c, state<=ACCUM, and cnt, win_q and mode_q are unchanged.
  - Any a_valid in the same cycle is ignored for accumulation but still propagates.
  - If preload_en arrives in EMPTY, win_q<=eff_win_len and mode_q<=mode are latched and cnt stays 0. The preload does not count as a sample.
- a_valid=0 samples: no change to acc or cnt.
- Reset or reg_clear mid-window: the partial window is discarded, no c_valid is produced, and c_out returns to 0.

Test Plan:
- MAX, win_len=4, samples 3, -7, 12, 5 (IA_W=16) -> single c_valid pulse on the 4th sample edge with c_out=12; a_out trails a by 1 cycle.
- MIN, win_len=3, samples -2, -9, 4, then mode switched to MAX mid-window -> c_out=-9 (sign-extended to 24 bits); the mode change is ignored.
- SUM, OC_W=16=IA_W, win_len=2, samples 0x7000 and 0x7000 -> c_out=0x7FFF (saturated); samples 0x8000 and 0x8000 -> c_out=0x8000.
- Back-to-back windows: MAX, win_len=2, stream 1, 2, 5, 4 with one a_valid=0 gap and one pipeline_en=0 stall inserted -> two pulses with c_out=2 then 5; no pulse during the gap or stall; c_valid=0 while stalled.
- Preload: preload_en with c=100, then MAX, win_len=2, samples 50, 60 -> c_out=100 after the 2nd sample. win_len=0 with sample 7 -> c_out=7 with a pulse on every sample.
- rst asserted asynchronously between clock edges after 2 of 4 samples -> all outputs 0 immediately. After release, 4 new samples 1, 2, 3, 4 in SUM -> c_out=10. reg_clear together with preload_en -> clear wins, state EMPTY.
